// File: rtl/kab_uart_tx.sv
// kab_uart_tx: memory-mapped 8N1 serial transmitter with a byte FIFO.
// Ports: Clock/Reset (async, active-low); WrEn/RdEn/Address/WrData/RdData
// form the register bus (0 DATA, 1 STATUS, 2 CTRL, 3 reserved);
// TxD is the serial line (idle high); IntReq is the level drain interrupt.
module kab_uart_tx #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        WrEn,
    input  logic        RdEn,
    input  logic [1:0]  Address,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        TxD,
    output logic        IntReq
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_DIV - 1);
    localparam logic [4:0]    DEPTH_C   = 5'(FIFO_DEPTH);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    idx_q, idx_d;
    logic          tx_q, tx_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    count;
    logic          overflow;
    logic          int_en;

    logic          empty, full, busy;
    logic          push_req, push, pop, bit_end;
    logic [31:0]   status, rd_mux;
    logic          unused_wrdata;

    assign unused_wrdata = ^WrData[31:8];

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign busy     = (state_q != S_IDLE);
    assign push_req = WrEn && (Address == ADDR_DATA);
    assign pop      = (state_q == S_IDLE) && !empty;
    // A full FIFO still takes a byte when the head leaves on the same edge.
    assign push     = push_req && (!full || pop);
    assign bit_end  = (baud_q == '0);

    assign status = {23'd0, count, overflow, busy, full, empty};
    assign TxD    = tx_q;

    // FIFO pointers and occupancy; pointers wrap naturally (power of two).
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) mem[wr_ptr] <= WrData[7:0];
    end

    // TX sequencer; tx_d is the line level for the current state, so the
    // registered TxD trails the state register by one cycle.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        tx_d    = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_START;
                    shift_d = mem[rd_ptr];
                    baud_d  = BAUD_LOAD;
                    idx_d   = '0;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    baud_d  = BAUD_LOAD;
                    idx_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    baud_d  = BAUD_LOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 3'd7) state_d = S_STOP;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    baud_d  = BAUD_LOAD;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (Address)
            ADDR_STATUS: rd_mux = status;
            ADDR_CTRL:   rd_mux = {31'd0, int_en};
            default:     rd_mux = '0;
        endcase
    end

    // Register side; an overflow in the same cycle as a STATUS read stays
    // set because the read already returned the pre-write value.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            RdData   <= '0;
            overflow <= 1'b0;
            int_en   <= 1'b0;
            IntReq   <= 1'b0;
        end else begin
            if (RdEn) RdData <= rd_mux;
            if (RdEn && (Address == ADDR_STATUS)) overflow <= 1'b0;
            if (push_req && full && !pop) overflow <= 1'b1;
            if (WrEn && (Address == ADDR_CTRL)) int_en <= WrData[0];
            IntReq <= int_en & empty & ~busy;
        end
    end

endmodule

// File: tb/tb_kab_uart_tx.sv
// tb_kab_uart_tx: self-checking bench for kab_uart_tx (CLK_DIV=4, depth 8).
// Register vectors from a table; serial bytes checked by a queue monitor.
module tb_kab_uart_tx;

    localparam int CD    = 4;
    localparam int DEPTH = 8;

    logic        Clock;
    logic        Reset;
    logic        WrEn;
    logic        RdEn;
    logic [1:0]  Address;
    logic [31:0] WrData;
    logic [31:0] RdData;
    logic        TxD;
    logic        IntReq;

    int          checks;
    int          errors;
    int          cyc;
    int          frames;
    logic        mon_en;
    logic [7:0]  exp_q[$];
    int          fall_q[$];

    typedef struct {
        logic        wr;
        logic        rd;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] erd;
        logic        eirq;
    } vec_t;

    vec_t tbl[16];

    kab_uart_tx #(
        .CLK_DIV    (CD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .WrEn    (WrEn),
        .RdEn    (RdEn),
        .Address (Address),
        .WrData  (WrData),
        .RdData  (RdData),
        .TxD     (TxD),
        .IntReq  (IntReq)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        WrEn = 1'b1;
        Address = a;
        WrData = d;
        @(posedge Clock);
        #1;
        WrEn = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        RdEn = 1'b1;
        Address = a;
        @(posedge Clock);
        #1;
        RdEn = 1'b0;
        v = RdData;
    endtask

    task automatic send(input logic [7:0] b);
        exp_q.push_back(b);
        wr(2'd0, {24'd0, b});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // Serial monitor: samples mid-bit on the falling clock edge.
    initial begin
        logic [7:0] got;
        logic [7:0] e;
        logic       bad;
        forever begin
            @(negedge Clock);
            if (mon_en && TxD === 1'b0) begin
                fall_q.push_back(cyc);
                bad = 1'b0;
                got = '0;
                repeat (CD / 2) @(negedge Clock);
                if (TxD !== 1'b0) bad = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    repeat (CD) @(negedge Clock);
                    got[i] = TxD;
                end
                repeat (CD) @(negedge Clock);
                if (TxD !== 1'b1) bad = 1'b1;
                repeat (CD - CD / 2 - 1) @(negedge Clock);
                frames++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame actual=%h required=none",
                             got);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame", {23'd0, bad, got}, {24'd0, e});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] last;
        logic [31:0] es;
        logic [7:0]  pat;
        logic        et;
        int          nbad;
        int          f0;
        int          diff;

        tbl[0]  = '{1'b0, 1'b1, 2'd1, 32'h0,        32'h001, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2'd2, 32'h1,        32'h001, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 2'd2, 32'h0,        32'h1,   1'b1};
        tbl[3]  = '{1'b1, 1'b0, 2'd3, 32'hFFFFFFFF, 32'h1,   1'b1};
        tbl[4]  = '{1'b0, 1'b1, 2'd3, 32'h0,        32'h0,   1'b1};
        tbl[5]  = '{1'b0, 1'b1, 2'd0, 32'h0,        32'h0,   1'b1};
        tbl[6]  = '{1'b0, 1'b1, 2'd2, 32'h0,        32'h1,   1'b1};
        tbl[7]  = '{1'b0, 1'b1, 2'd1, 32'h0,        32'h001, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 2'd2, 32'hFFFFFFFE, 32'h001, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 2'd2, 32'h0,        32'h0,   1'b0};
        tbl[10] = '{1'b1, 1'b0, 2'd2, 32'h3,        32'h0,   1'b0};
        tbl[11] = '{1'b0, 1'b1, 2'd2, 32'h0,        32'h1,   1'b1};
        tbl[12] = '{1'b1, 1'b1, 2'd2, 32'h0,        32'h1,   1'b1};
        tbl[13] = '{1'b0, 1'b1, 2'd2, 32'h0,        32'h0,   1'b0};
        tbl[14] = '{1'b1, 1'b0, 2'd2, 32'h1,        32'h0,   1'b0};
        tbl[15] = '{1'b0, 1'b0, 2'd0, 32'h0,        32'h0,   1'b1};

        checks = 0;
        errors = 0;
        frames = 0;
        cyc = 0;
        mon_en = 1'b0;
        Reset = 1'b0;
        WrEn = 1'b0;
        RdEn = 1'b0;
        Address = 2'd0;
        WrData = '0;

        // Reset values
        idle(3);
        chk("rst_txd", TxD, 1);
        chk("rst_rddata", RdData, 0);
        chk("rst_intreq", IntReq, 0);
        Reset = 1'b1;
        idle(1);
        rd(2'd1, v);
        chk("rst_status", v, 32'h001);

        // Reset mid-frame
        wr(2'd0, 32'h3C);
        idle(10);
        chk("midframe_low", TxD, 0);
        Reset = 1'b0;
        #1;
        chk("async_txd", TxD, 1);
        chk("async_rddata", RdData, 0);
        chk("async_intreq", IntReq, 0);
        idle(2);
        Reset = 1'b1;
        idle(1);
        rd(2'd1, v);
        chk("post_rst_status", v, 32'h001);
        chk("post_rst_intreq", IntReq, 0);
        nbad = 0;
        for (int i = 0; i < 60; i++) begin
            idle(1);
            if (TxD !== 1'b1) nbad++;
        end
        chk("no_retransmit", nbad, 0);

        // Single byte 0xA5: line and STATUS traced every cycle
        mon_en = 1'b1;
        pat = 8'hA5;
        send(pat);
        for (int k = 1; k <= 42; k++) begin
            RdEn = 1'b1;
            Address = 2'd1;
            @(posedge Clock);
            #1;
            if (k == 1 || k == 42)  et = 1'b1;
            else if (k <= 5)        et = 1'b0;
            else if (k >= 38)       et = 1'b1;
            else                    et = pat[(k - 6) / 4];
            if (k == 1)       es = 32'h010;
            else if (k == 42) es = 32'h001;
            else              es = 32'h005;
            chk($sformatf("a5_txd_k%0d", k), TxD, et);
            chk($sformatf("a5_status_k%0d", k), RdData, es);
        end
        RdEn = 1'b0;
        idle(5);

        // Back-to-back frames
        fall_q.delete();
        send(8'h00);
        send(8'hFF);
        idle(8);
        rd(2'd1, v);
        chk("b2b_status", v, 32'h014);
        idle(90);
        chk("b2b_frames", fall_q.size(), 2);
        diff = (fall_q.size() >= 2) ? fall_q[1] - fall_q[0] : -1;
        chk("b2b_start_gap", diff, 10 * CD + 1);

        // Overflow
        f0 = frames;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) send(8'(8'h10 + i));
            else       wr(2'd0, 32'h19);
        end
        rd(2'd1, v);
        chk("ovf_status", v, 32'h08E);
        rd(2'd1, v);
        chk("ovf_cleared", v, 32'h086);
        idle(400);
        chk("ovf_frames", frames - f0, 9);
        chk("ovf_queue", exp_q.size(), 0);

        // Full FIFO plus a write on the pop cycle
        for (int i = 0; i < 9; i++) send(8'(8'h40 + i));
        idle(33);
        send(8'h7E);
        rd(2'd1, v);
        chk("full_pop_status", v, 32'h086);
        idle(450);
        chk("full_pop_queue", exp_q.size(), 0);

        // Register vectors
        last = '0;
        for (int i = 0; i < 16; i++) begin
            WrEn = tbl[i].wr;
            RdEn = tbl[i].rd;
            Address = tbl[i].a;
            WrData = tbl[i].d;
            @(posedge Clock);
            #1;
            WrEn = 1'b0;
            RdEn = 1'b0;
            if (tbl[i].rd) last = tbl[i].erd;
            chk($sformatf("vec%0d_rddata", i), RdData, last);
            chk($sformatf("vec%0d_intreq", i), IntReq, tbl[i].eirq);
        end

        // Interrupt across a frame
        send(8'h81);
        chk("irq_at_push", IntReq, 1);
        idle(1);
        chk("irq_drop", IntReq, 0);
        idle(40);
        chk("irq_in_stop", IntReq, 0);
        idle(1);
        chk("irq_reassert", IntReq, 1);
        wr(2'd2, 32'h0);
        chk("irq_ctrl_edge", IntReq, 1);
        idle(1);
        chk("irq_ctrl_clear", IntReq, 0);

        idle(20);
        chk("final_queue", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kab_uart_tx.md
# kab_uart_tx

Memory-mapped serial transmitter that takes the place of the stub `Dout` pin driver at the chip boundary. It sits directly downstream of the KabIO bus fabric in the IO clock domain. Bytes written by the core are buffered in a FIFO and shifted out as 8N1 frames on `TxD`. An interrupt request is raised toward the interrupt controller when the transmitter drains.

## Interface
- `CLK_DIV`, 434: IO clock cycles per bit (≥2); 434 gives 115200 baud at 50 MHz.
- `FIFO_DEPTH`, 8: transmit FIFO entries; power of two, 2..16.
- `Clock` in 1: IO clock; the block's only clock.
- `Reset` in 1: asynchronous, active-low reset.
- `WrEn` in 1: register write strobe, one cycle per access.
- `RdEn` in 1: register read strobe, one cycle per access.
- `Address` in 2: register select: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved.
- `WrData` in 32: write data.
- `RdData` out 32: read data, registered.
- `TxD` out 1: serial output, idle high.
- `IntReq` out 1: level interrupt request.

## Operation
- Registers:
  - DATA (W): pushes `WrData[7:0]` into the FIFO. Reads return 0.
  - STATUS (R): bit0 empty, bit1 full, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[8:4] FIFO count. All other bits 0. Reading STATUS clears overflow.
  - CTRL (R/W): bit0 IntEn. Other bits read 0.
  - Address 3 reads 0 and ignores writes.
- FIFO:
  - A push is accepted if count < FIFO_DEPTH, or if a pop happens in the same cycle. In the same-cycle case count is unchanged.
  - A write to a full FIFO with no pop that cycle is dropped and sets overflow.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, load the baud counter with CLK_DIV-1, and go to START.
  - START: `TxD`=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: `TxD`=shift[0] for CLK_DIV cycles. Then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: `TxD`=1 for CLK_DIV cycles, then go to IDLE.
  - Bits go out LSB first.
- Baud counter: counts down from CLK_DIV-1. The bit period ends when the counter is 0 and is reloaded on the same edge.
- `IntReq` = IntEn & empty & ~busy, registered.
- If `WrEn` and `RdEn` are both asserted, both take effect. A STATUS read in that cycle returns the values from before the write.
- Reset mid-frame: `TxD` returns high immediately (asynchronous) and any partial frame is abandoned. After reset release the FIFO is empty, the FSM is IDLE and no retransmission occurs.

## Timing
- Reset values: `TxD`=1, `RdData`=0, `IntReq`=0, FIFO empty, overflow=0, IntEn=0, FSM IDLE.
- Read latency is 1 cycle: `RdData` is valid on the edge after the `RdEn` edge. `RdData` holds its value until the next read.
- Write to DATA while IDLE with an empty FIFO (edge t):
  - Count becomes 1 at t.
  - Pop occurs at t+1.
  - `TxD` falls at t+2.
- Frame length is exactly 10·CLK_DIV cycles from the `TxD` falling edge to the end of the stop bit.
- Back-to-back frames: IDLE lasts exactly 1 cycle between the end of STOP and the next START. The line is high for CLK_DIV+1 cycles between start bits.
- `IntReq` asserts 1 cycle after the FSM enters IDLE with the FIFO empty and IntEn=1. It deasserts 1 cycle after a push or after IntEn is cleared.
- `busy` (STATUS bit2) reflects the registered FSM state.

## Test plan
- Reset check: assert `Reset`=0 mid-frame with CLK_DIV=4 → `TxD`=1 immediately. After release STATUS reads 0x001 and `IntReq`=0.
- Single byte, CLK_DIV=4: write 0xA5 to DATA → `TxD` falls 2 cycles later. The line then carries 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. Busy drops after 40 cycles.
- Back-to-back: write 0x00 then 0xFF on consecutive cycles → two frames with exactly 5 high cycles between start bits. The FIFO count reads 1 during the first frame.
- Overflow, FIFO_DEPTH=8, CLK_DIV=4: write 10 bytes while the first frame is in START. The write that would make count exceed 8 is dropped. STATUS shows full=1 and overflow=1; a second STATUS read shows overflow=0. Exactly 9 frames are sent.
- Full plus simultaneous pop: fill 8 entries with the FSM idle-blocked, then write on the pop cycle → write accepted, count stays 8, overflow stays 0.
- Interrupt: write CTRL=1 with an empty FIFO → `IntReq`=1 after 1 cycle. Write DATA → `IntReq`=0 after 1 cycle. `IntReq` reasserts 1 cycle after STOP ends. Writing CTRL=0 clears it.
